// File: rtl/axi_lite_reg_master.sv
// rtl/axi_lite_reg_master.sv - single-outstanding command/response to AXI-lite master bridge
// Every AXI wait state is bounded by a per-state timeout that aborts with SLVERR.
module axi_lite_reg_master #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic [1:0]            o_rsp_resp,
    output logic                  o_rsp_timeout,
    output logic                  o_awvalid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic                  i_wready,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_arvalid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [1:0]            i_rresp,
    input  logic [DATA_WIDTH-1:0] i_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  aw_done;
    logic                  w_done;
    logic [CNT_W-1:0]      cnt;
    logic                  cmd_ready_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic                  rsp_timeout_q;

    logic cmd_accept;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic waiting;
    logic timeout_hit;

    assign o_cmd_ready   = cmd_ready_q;
    assign o_awvalid     = (state == WR_ADDR_DATA) && !aw_done;
    assign o_wvalid      = (state == WR_ADDR_DATA) && !w_done;
    assign o_bready      = (state == WR_RESP);
    assign o_arvalid     = (state == RD_ADDR);
    assign o_rready      = (state == RD_DATA);
    assign o_rsp_valid   = (state == RSP);
    assign o_awaddr      = addr_q;
    assign o_araddr      = addr_q;
    assign o_wdata       = wdata_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_timeout_q;

    assign cmd_accept  = i_cmd_valid && cmd_ready_q;
    assign aw_hs       = o_awvalid && i_awready;
    assign w_hs        = o_wvalid && i_wready;
    assign b_hs        = o_bready && i_bvalid;
    assign ar_hs       = o_arvalid && i_arready;
    assign r_hs        = o_rready && i_rvalid;
    assign waiting     = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                         (state == RD_ADDR) || (state == RD_DATA);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A handshake completing in the timeout cycle still wins over the abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_accept) begin
                    state_next = i_cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = WR_RESP;
                end else if (timeout_hit) begin
                    state_next = RSP;
                end
            end
            WR_RESP: begin
                if (b_hs || timeout_hit) begin
                    state_next = RSP;
                end
            end
            RD_ADDR: begin
                if (ar_hs) begin
                    state_next = RD_DATA;
                end else if (timeout_hit) begin
                    state_next = RSP;
                end
            end
            RD_DATA: begin
                if (r_hs || timeout_hit) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            cnt           <= '0;
            cmd_ready_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state       <= state_next;
            cmd_ready_q <= (state_next == IDLE);

            if (state_next != state) begin
                cnt <= '0;
            end else if (waiting) begin
                cnt <= cnt + 1'b1;
            end

            if (cmd_accept) begin
                addr_q  <= i_cmd_addr;
                wdata_q <= i_cmd_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end

            // Entering RSP without a B or R handshake can only be a timeout.
            if (state_next == RSP && state != RSP) begin
                if (b_hs) begin
                    rsp_rdata_q   <= '0;
                    rsp_resp_q    <= i_bresp;
                    rsp_timeout_q <= 1'b0;
                end else if (r_hs) begin
                    rsp_rdata_q   <= i_rdata;
                    rsp_resp_q    <= i_rresp;
                    rsp_timeout_q <= 1'b0;
                end else begin
                    rsp_rdata_q   <= '0;
                    rsp_resp_q    <= 2'b10;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/axi_lite_reg_master.md
AXI_LITE_REG_MASTER -- requirements
Module: axi_lite_reg_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 16, AXI address width; DATA_WIDTH, 32, AXI data width; TIMEOUT_CYCLES, 1024, max cycles waiting on any AXI handshake (>=2).
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_cmd_valid  in  1  command offered; o_cmd_ready  out  1  command accepted when both high.
REQ-005 i_cmd_write  in  1  1=write, 0=read; i_cmd_addr  in  ADDR_WIDTH; i_cmd_wdata  in  DATA_WIDTH.
REQ-006 o_rsp_valid  out  1; i_rsp_ready  in  1; o_rsp_rdata  out  DATA_WIDTH; o_rsp_resp  out  2  AXI resp code; o_rsp_timeout  out  1  transaction aborted.
REQ-007 AXI-lite master: o_awvalid, o_awaddr[ADDR_WIDTH], i_awready; o_wvalid, o_wdata[DATA_WIDTH], i_wready; i_bvalid, o_bready, i_bresp[2].
REQ-008 AXI-lite master: o_arvalid, o_araddr[ADDR_WIDTH], i_arready; i_rvalid, o_rready, i_rresp[2], i_rdata[DATA_WIDTH].

Function
REQ-009 States SHALL be IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-010 o_cmd_ready SHALL be 1 only in IDLE; one command in flight, no pipelining.
REQ-011 On cmd accept, addr/wdata/write SHALL be latched; write -> WR_ADDR_DATA, read -> RD_ADDR, next cycle.
REQ-012 WR_ADDR_DATA: o_awvalid and o_wvalid SHALL assert together on entry; each drops the cycle after its own ready handshake, independently; AW/W may complete in either order or same cycle.
REQ-013 Once both AW and W handshakes done -> WR_RESP with o_bready=1; on i_bvalid&o_bready latch i_bresp, o_rsp_rdata=0 -> RSP.
REQ-014 RD_ADDR: o_arvalid=1 until i_arready, then RD_DATA with o_rready=1; on i_rvalid&o_rready latch i_rdata, i_rresp -> RSP.
REQ-015 valid signals SHALL NOT drop before their handshake except on timeout or reset; addr/data SHALL stay stable while valid.
REQ-016 RSP: o_rsp_valid=1, outputs stable until i_rsp_ready; then -> IDLE next cycle. Min command-to-response latency: 3 cycles with zero-wait slave.
REQ-017 Timeout counter SHALL clear on each state entry and increment each cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA; at TIMEOUT_CYCLES-1 without completing handshake: deassert all AXI valid/ready, o_rsp_resp=2'b10, o_rsp_timeout=1, o_rsp_rdata=0, -> RSP.
REQ-018 o_rsp_timeout SHALL be 0 for normally completed transactions; SLVERR/DECERR from slave SHALL pass through unmodified.
REQ-019 i_bvalid/i_rvalid arriving in any state other than WR_RESP/RD_DATA SHALL be ignored (o_bready/o_rready=0).
REQ-020 i_cmd_valid while not IDLE SHALL be ignored; command inputs need not be held after accept.

Reset
REQ-021 rst SHALL force IDLE and zero all outputs except o_cmd_ready, which SHALL be 1 the cycle after rst deasserts.
REQ-022 rst mid-transaction SHALL abort immediately: all valid/ready low next cycle, no response emitted; latched command discarded.
REQ-023 Timeout counter and latched resp/data SHALL reset to 0.

Verification
REQ-024 Write addr 0x0000 data 0x0ca7cafe, slave awready/wready same cycle, bvalid next, bresp=0 -> rsp_valid with resp=0, timeout=0, 3 cycles after accept.
REQ-025 Write with wready 5 cycles before awready -> o_wvalid drops after W handshake, o_awvalid held; single response resp=0.
REQ-026 Read addr 0x0004, slave returns 0x12345678 rresp=2 after 4-cycle arready stall -> rsp rdata=0x12345678 resp=2, timeout=0.
REQ-027 Read with slave never asserting arready, TIMEOUT_CYCLES=16 -> o_arvalid low and rsp resp=2, timeout=1, rdata=0, 16 cycles after RD_ADDR entry.
REQ-028 Hold i_rsp_ready=0 for 10 cycles -> response outputs stable, o_cmd_ready=0 throughout; back-to-back cmd accepted cycle after rsp handshake.
REQ-029 Assert rst during WR_RESP -> all outputs zero next cycle, no rsp_valid, o_cmd_ready=1 cycle after release.
